// File: rtl/counter_volts_sweep.sv
// DAC voltage-code counter with programmable step, limits, direction, wrap/saturate
// and an autonomous sweep FSM with per-code dwell; strobes step_o on every code change.
module counter_volts_sweep #(
  parameter int unsigned Width  = 12,
  parameter int unsigned DwellW = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        opc_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              dir_i,
  input  logic              wrap_i,
  input  logic [Width-1:0]  step_i,
  input  logic [Width-1:0]  min_i,
  input  logic [Width-1:0]  max_i,
  input  logic [DwellW-1:0] dwell_i,
  output logic [Width-1:0]  count_o,
  output logic              step_o,
  output logic              tc_o,
  output logic              wrap_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DWELL = 2'd1,
    S_STEP  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [Width-1:0]    count_q, count_d;
  logic [DwellW-1:0]   dwell_q, dwell_d;
  logic                step_q, step_d;
  logic                wrap_q, wrap_d;
  logic                done_q, done_d;
  logic                cdir_q, cdir_d;
  logic                cwrap_q, cwrap_d;
  logic [Width-1:0]    cstep_q, cstep_d;
  logic [Width-1:0]    cmin_q, cmin_d;
  logic [Width-1:0]    cmax_q, cmax_d;
  logic [DwellW-1:0]   cdwell_q, cdwell_d;

  logic [Width:0]      live_res, lat_res;
  logic                tc_live, tc_lat;

  // Returns {wrap_flag, next_code}; only the limit in the active direction is checked.
  function automatic logic [Width:0] step_calc(
    input logic [Width-1:0] cnt,
    input logic [Width-1:0] stp,
    input logic [Width-1:0] mn,
    input logic [Width-1:0] mx,
    input logic             dn,
    input logic             wr
  );
    logic [Width:0] inc;
    logic [Width:0] sum;
    logic [Width:0] lo;
    logic [Width:0] res;
    inc = (stp == '0) ? {{Width{1'b0}}, 1'b1} : {1'b0, stp};
    sum = {1'b0, cnt} + inc;
    lo  = {1'b0, mn} + inc;
    if (!dn) begin
      if (sum > {1'b0, mx}) res = wr ? {1'b1, mn} : {1'b0, mx};
      else                  res = {1'b0, sum[Width-1:0]};
    end else begin
      if ({1'b0, cnt} < lo) res = wr ? {1'b1, mx} : {1'b0, mn};
      else                  res = {1'b0, cnt - inc[Width-1:0]};
    end
    return res;
  endfunction

  assign live_res = step_calc(count_q, step_i, min_i, max_i, dir_i, wrap_i);
  assign lat_res  = step_calc(count_q, cstep_q, cmin_q, cmax_q, cdir_q, cwrap_q);

  assign tc_live = dir_i  ? (count_q == min_i)  : (count_q == max_i);
  assign tc_lat  = cdir_q ? (count_q == cmin_q) : (count_q == cmax_q);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    dwell_d  = dwell_q;
    wrap_d   = 1'b0;
    done_d   = 1'b0;
    cdir_d   = cdir_q;
    cwrap_d  = cwrap_q;
    cstep_d  = cstep_q;
    cmin_d   = cmin_q;
    cmax_d   = cmax_q;
    cdwell_d = cdwell_q;
    unique case (state_q)
      S_IDLE: begin
        // An invalid start (min > max) still suppresses the manual command.
        if (start_i) begin
          if (min_i <= max_i) begin
            cdir_d   = dir_i;
            cwrap_d  = wrap_i;
            cstep_d  = step_i;
            cmin_d   = min_i;
            cmax_d   = max_i;
            cdwell_d = dwell_i;
            count_d  = dir_i ? max_i : min_i;
            dwell_d  = dwell_i;
            state_d  = S_DWELL;
          end
        end else begin
          unique case (opc_i)
            2'b00: count_d = '0;
            2'b01: count_d = count_q;
            2'b10: {wrap_d, count_d} = live_res;
            2'b11: count_d = min_i;
            default: count_d = count_q;
          endcase
        end
      end
      S_DWELL: begin
        if (abort_i)              state_d = S_IDLE;
        else if (dwell_q != '0)   dwell_d = dwell_q - 1'b1;
        else                      state_d = S_STEP;
      end
      S_STEP: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (!cwrap_q && tc_lat) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          {wrap_d, count_d} = lat_res;
          dwell_d = cdwell_q;
          state_d = S_DWELL;
        end
      end
      default: state_d = S_IDLE;
    endcase
    step_d = (count_d != count_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      dwell_q  <= '0;
      step_q   <= 1'b0;
      wrap_q   <= 1'b0;
      done_q   <= 1'b0;
      cdir_q   <= 1'b0;
      cwrap_q  <= 1'b0;
      cstep_q  <= '0;
      cmin_q   <= '0;
      cmax_q   <= '0;
      cdwell_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      dwell_q  <= dwell_d;
      step_q   <= step_d;
      wrap_q   <= wrap_d;
      done_q   <= done_d;
      cdir_q   <= cdir_d;
      cwrap_q  <= cwrap_d;
      cstep_q  <= cstep_d;
      cmin_q   <= cmin_d;
      cmax_q   <= cmax_d;
      cdwell_q <= cdwell_d;
    end
  end

  assign count_o = count_q;
  assign step_o  = step_q;
  assign wrap_o  = wrap_q;
  assign done_o  = done_q;
  assign busy_o  = (state_q != S_IDLE);
  assign tc_o    = (state_q == S_IDLE) ? tc_live : tc_lat;

endmodule

// File: doc/counter_volts_sweep.md
Name: counter_volts_sweep

Overview:
- Parametrised successor to the DAC voltage-code counter; drives the code word sent to the DAC serialiser.
- Adds programmable step size, min/max limits, up/down direction and saturate/wrap modes.
- Adds an autonomous sweep FSM with a programmable dwell time per code.
- Emits a one-cycle strobe whenever the code changes, so the DAC transmit path can fire.

Parameters:
- Width, 12, bit width of the DAC code and of step_i/min_i/max_i.
- DwellW, 16, bit width of the dwell counter and dwell_i.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  reset; asynchronous, active-high.
- opc_i  input  2  manual command, acted on in IDLE only: 00 clear, 01 hold, 10 step, 11 load min.
- start_i  input  1  begin sweep (level sampled in IDLE).
- abort_i  input  1  stop sweep, return to IDLE.
- dir_i  input  1  0 up, 1 down.
- wrap_i  input  1  0 saturate at limit, 1 wrap to opposite limit.
- step_i  input  Width  increment magnitude; value 0 is treated as 1.
- min_i  input  Width  lower code limit.
- max_i  input  Width  upper code limit.
- dwell_i  input  DwellW  extra hold cycles per code during sweep.
- count_o  output  Width  current DAC code (registered).
- step_o  output  1  one-cycle pulse, high in the cycle count_o takes a new value.
- tc_o  output  1  count_o equals the limit in the active direction.
- wrap_o  output  1  one-cycle pulse, high the cycle a wrap occurs.
- busy_o  output  1  high while in DWELL or STEP.
- done_o  output  1  one-cycle pulse when a saturating sweep completes.

Behaviour:
- Reset: FSM to IDLE; count_o=0; dwell counter=0; step_o, wrap_o, done_o, busy_o all 0; latched config regs cleared.
- Arithmetic uses Width+1 bits.
  - Up: sum=count+step. If sum>max: saturate gives max; wrap gives min with wrap_o=1.
  - Down: if count<min+step (computed in Width+1 bits): saturate gives min; wrap gives max with wrap_o=1. Otherwise count-step.
  - Only the limit in the active direction is checked. A count outside [min,max] on the other side moves normally.
- tc_o is combinational from count_o. In IDLE it compares against max_i when dir_i=0, min_i when dir_i=1; in DWELL/STEP it compares against the latched limit for the latched direction.
- step_o is registered and fires only if the new value differs from the old. Example: a saturate-step already at max gives step_o=0.
- IDLE:
  - start_i has priority over opc_i.
  - opc 00: count=0.
  - opc 01: hold.
  - opc 10: one step using live dir_i/wrap_i/step_i/min_i/max_i.
  - opc 11: count=min_i.
  - start_i=1 with min_i<=max_i: latch dir, wrap, step, min, max, dwell. Count becomes min (up) or max (down); go to DWELL with dwell counter=dwell_i.
  - start_i=1 with min_i>max_i: start is ignored, count is held, and opc_i is also ignored that cycle.
- DWELL:
  - busy_o=1.
  - If counter≠0, decrement it.
  - If counter=0, go to STEP.
  - Each code is therefore held dwell_i+1 cycles in DWELL, plus 1 cycle in STEP.
- STEP:
  - Saturate mode with tc already true: no change; done_o pulses next cycle; go to IDLE.
  - Otherwise apply one step with the latched config, reload the dwell counter, and return to DWELL.
  - Wrap mode never finishes; it loops until abort.
- abort_i in DWELL/STEP: go to IDLE next cycle; count_o held; no done_o. abort_i has priority over the STEP update in the same cycle.
- Inputs changed during a sweep have no effect until the next start.
- rst_i asserted mid-sweep forces the reset values immediately (asynchronous).

Test Plan:
- Reset with opc_i=10 -> count_o=0, all pulses low. After release, 3 cycles of opc 10 with step_i=1, up, min=0, max=4095 -> count 1,2,3, with step_o high each cycle.
- IDLE, count=4090, step=10, up, saturate, max=4095: opc 10 -> count=4095, tc_o=1. A second opc 10 -> count stays 4095, step_o=0.
- Same case with wrap_i=1, min=100 -> count=100, wrap_o pulses once. Down from 105, step=10, min=100, wrap -> count=max_i.
- Sweep min=0, max=20, step=5, dwell=2, up, saturate -> count 0,5,10,15,20 with 4 cycles per code. done_o pulses once after 20; busy_o=0 afterwards.
- Sweep in wrap mode, min=0, max=10, step=4 -> sequence 0,4,8,0,4… with wrap_o at each 8→0. abort_i mid-DWELL -> IDLE next cycle, count held.
- start_i with min=50, max=40 -> no state change. rst_i pulsed mid-sweep -> count_o=0 and IDLE asynchronously.
